ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-register load/store sequencer for block transfers (LDM/STM) in the memory stage; sits directly upstream of the word-wide data memory and drives its address, write-enable and write-data inputs.
- Accepts one block-transfer command from execute.
- Walks the 16-bit register list lowest-index-first, one word per cycle.
- Stalls the pipeline while busy, then issues the optional base-register writeback.

Parameters:
- ADDR_STEP, 4, address increment between consecutive transfers (4 = byte addressing; set 1 for word-indexed memory).
- ADDR_W, 32, address/data width.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle command strobe from execute; sampled only in IDLE.
- IsLoad  input  1  1 = LDM, 0 = STM.
- PreIndex  input  1  P bit.
- Up  input  1  U bit.
- WriteBack  input  1  W bit.
- BaseReg  input  4  Rn index.
- BaseAddr  input  ADDR_W  value of Rn.
- RegList  input  16  register list, bit i = Ri.
- MemAddress  output  ADDR_W  to data memory Address.
- MemWE  output  1  to data memory WE.
- MemWD  output  ADDR_W  to data memory WD.
- MemRD  input  ADDR_W  data memory ReadData (combinational read).
- RegRA  output  4  register-file read index for stores.
- RegRD  input  ADDR_W  register-file read data (combinational).
- RegWE  output  1  register-file write enable.
- RegWA  output  4  register-file write index.
- RegWD  output  ADDR_W  register-file write data.
- Stall  output  1  freeze upstream stages.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- States and transitions:
  - IDLE: Start=1 goes to XFER if RegList!=0, else to FINISH.
  - XFER: stays in XFER until the last set bit is transferred, then goes to FINISH.
  - FINISH: goes to IDLE after one cycle.
- Latched on Start in IDLE:
  - N = popcount(RegList), range 0..16.
  - Pending = RegList.
  - IsLoad, WriteBack, BaseReg.
  - Start address, per mode:
    - IA (P=0,U=1): BaseAddr.
    - IB (P=1,U=1): BaseAddr+ADDR_STEP.
    - DA (P=0,U=0): BaseAddr-(N-1)*ADDR_STEP.
    - DB (P=1,U=0): BaseAddr-N*ADDR_STEP.
  - NewBase = BaseAddr±N*ADDR_STEP (+ if U=1).
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Each XFER cycle:
  - Idx = lowest set bit of Pending.
  - MemAddress = current address.
  - Stores: RegRA = Idx; MemWD = RegRD; MemWE = 1.
  - Loads: MemWE = 0; RegWE = 1; RegWA = Idx; RegWD = MemRD in the same cycle.
  - On the clock edge: clear Idx from Pending; address += ADDR_STEP.
- FINISH:
  - Done = 1.
  - If WriteBack=1: RegWE = 1, RegWA = BaseReg, RegWD = NewBase.
  - Exception: on a load whose RegList contains BaseReg, the base writeback is suppressed and the loaded value stands.
- Stall = 1 whenever state != IDLE. It is also 1 combinationally in the IDLE cycle where Start=1.
- Latency: N+1 cycles from the Start edge to Done; an empty list takes 1 cycle.
- Start while not IDLE is ignored.
- Defaults when inactive: MemWE, RegWE and Done are 0; MemAddress, MemWD and RegWD hold 0.
- Reset (any time, including mid-transfer): state returns to IDLE, all registers clear, all outputs 0 asynchronously.
  - A partially completed STM leaves already-written words in memory.
  - No writeback occurs.
- R15 in the list is transferred like any other register. PC redirect is the register file's concern.

Decomposition:
- Shared package ldm_stm_pkg holds:
  - the state encoding constants (IDLE=2'd0, XFER=2'd1, FINISH=2'd2);
  - the addressing-mode encodings {P,U}.
- One natural sub-module: reglist_scan, a combinational lowest-set-bit priority encoder plus popcount over 16 bits.

Test Plan:
- STMIA, Rn=R13=0x100, list {R0,R2,R5}, W=1:
  - writes R0→0x100, R2→0x104, R5→0x108;
  - R13←0x10C in the FINISH cycle;
  - Done 4 cycles after Start.
- LDMDB, Rn=0x200, list {R1,R3}, memory preloaded:
  - reads 0x1F8→R1 and 0x1FC→R3;
  - MemWE stays 0;
  - with W=1, R(Rn)←0x1F8.
- LDMIA, Rn=R4, list includes R4, W=1: R4 ends with the loaded word, not the written-back base.
- Empty list: Done asserted 1 cycle after Start; no MemWE/RegWE activity.
- Full list 0xFFFF, STMIB, base 0xFFFFFFF8:
  - 16 writes with addresses wrapping through 0x00000000;
  - Stall high for 17 cycles.
- Reset asserted on the 2nd XFER cycle of a 3-register STM:
  - outputs drop to 0 immediately;
  - only the first word is written;
  - next Start proceeds normally.

Source files
------------

// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
//   - FSM state encoding
//   - addressing-mode encodings, indexed by {P, U}
//   - register-list geometry
package ldm_stm_pkg;

  localparam int unsigned LIST_W = 16;  // register-list width
  localparam int unsigned IDX_W  = 4;   // register index width
  localparam int unsigned CNT_W  = 5;   // popcount width, 0..16

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Addressing modes, indexed by {PreIndex, Up}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/ldm_stm_sequencer_reglist_scan.sv
// Combinational register-list scanner.
// Ports:
//   list_i  - 16-bit register list
//   idx_o   - index of the lowest set bit (0 when the list is empty)
//   count_o - number of set bits, 0..16
module reglist_scan
  import ldm_stm_pkg::*;
(
  input  logic [LIST_W-1:0] list_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [CNT_W-1:0]  count_o
);

  // Priority encoder: scanning downward lets the lowest set bit win
  always_comb begin
    idx_o = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_i[i]) idx_o = IDX_W'(i);
    end
  end

  // Population count
  always_comb begin
    count_o = '0;
    for (int i = 0; i < LIST_W; i++) begin
      count_o = count_o + CNT_W'(list_i[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer (LDM/STM) for the memory stage.
// Ports:
//   CLK, Reset            - clock, async active-high reset
//   Start, IsLoad,
//   PreIndex, Up,
//   WriteBack, BaseReg,
//   BaseAddr, RegList     - block-transfer command from execute
//   MemAddress/WE/WD, MemRD - data-memory interface (combinational read)
//   RegRA, RegRD          - register-file read port (stores)
//   RegWE/WA/WD           - register-file write port (loads, base writeback)
//   Stall                 - freeze upstream stages while busy
//   Done                  - one-cycle completion pulse
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              IsLoad,
  input  logic              PreIndex,
  input  logic              Up,
  input  logic              WriteBack,
  input  logic [3:0]        BaseReg,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [15:0]       RegList,
  output logic [ADDR_W-1:0] MemAddress,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemWD,
  input  logic [ADDR_W-1:0] MemRD,
  output logic [3:0]        RegRA,
  input  logic [ADDR_W-1:0] RegRD,
  output logic              RegWE,
  output logic [3:0]        RegWA,
  output logic [ADDR_W-1:0] RegWD,
  output logic              Stall,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_e              state_q, state_d;
  logic [LIST_W-1:0]   pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   new_base_q, new_base_d;
  logic                is_load_q, is_load_d;
  logic                wb_q, wb_d;
  logic [IDX_W-1:0]    base_reg_q, base_reg_d;
  logic                base_in_list_q, base_in_list_d;

  logic [LIST_W-1:0]   scan_list;
  logic [IDX_W-1:0]    scan_idx;
  logic [CNT_W-1:0]    scan_cnt;
  logic [ADDR_W-1:0]   span;
  logic [ADDR_W-1:0]   start_addr;
  logic [LIST_W-1:0]   pending_next;

  // One scanner serves both phases: popcount of the incoming list in IDLE,
  // lowest pending index during XFER.
  assign scan_list = (state_q == IDLE) ? RegList : pending_q;

  reglist_scan u_scan (
    .list_i  (scan_list),
    .idx_o   (scan_idx),
    .count_o (scan_cnt)
  );

  // N*ADDR_STEP, modulo 2^ADDR_W
  assign span = ADDR_W'(scan_cnt) * STEP;

  // Lowest transfer address for each addressing mode
  always_comb begin
    start_addr = BaseAddr;
    unique case ({PreIndex, Up})
      MODE_IA: start_addr = BaseAddr;
      MODE_IB: start_addr = BaseAddr + STEP;
      MODE_DA: start_addr = BaseAddr - span + STEP;
      MODE_DB: start_addr = BaseAddr - span;
      default: start_addr = BaseAddr;
    endcase
  end

  assign pending_next = pending_q & ~(LIST_W'(1) << scan_idx);

  // State and command registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      addr_q         <= '0;
      new_base_q     <= '0;
      is_load_q      <= 1'b0;
      wb_q           <= 1'b0;
      base_reg_q     <= '0;
      base_in_list_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      addr_q         <= addr_d;
      new_base_q     <= new_base_d;
      is_load_q      <= is_load_d;
      wb_q           <= wb_d;
      base_reg_q     <= base_reg_d;
      base_in_list_q <= base_in_list_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    addr_d         = addr_q;
    new_base_d     = new_base_q;
    is_load_d      = is_load_q;
    wb_d           = wb_q;
    base_reg_d     = base_reg_q;
    base_in_list_d = base_in_list_q;

    MemAddress = '0;
    MemWE      = 1'b0;
    MemWD      = '0;
    RegRA      = '0;
    RegWE      = 1'b0;
    RegWA      = '0;
    RegWD      = '0;
    Stall      = 1'b0;
    Done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Freeze upstream in the same cycle the command is presented
        Stall = Start & ~Reset;
        if (Start) begin
          state_d        = (RegList != '0) ? XFER : FINISH;
          pending_d      = RegList;
          addr_d         = start_addr;
          new_base_d     = Up ? (BaseAddr + span) : (BaseAddr - span);
          is_load_d      = IsLoad;
          wb_d           = WriteBack;
          base_reg_d     = BaseReg;
          base_in_list_d = RegList[BaseReg];
        end
      end
      XFER: begin
        Stall      = 1'b1;
        MemAddress = addr_q;
        if (is_load_q) begin
          RegWE = 1'b1;
          RegWA = scan_idx;
          RegWD = MemRD;
        end else begin
          RegRA = scan_idx;
          MemWD = RegRD;
          MemWE = 1'b1;
        end
        pending_d = pending_next;
        addr_d    = addr_q + STEP;
        if (pending_next == '0) state_d = FINISH;
      end
      FINISH: begin
        Stall   = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
        // A loaded base register keeps its loaded value
        if (wb_q && !(is_load_q && base_in_list_q)) begin
          RegWE = 1'b1;
          RegWA = base_reg_q;
          RegWD = new_base_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: behavioural memory and register
// file, reference model built from the block-transfer addressing rules.
module tb_ldm_stm_sequencer;

  localparam int unsigned STEP = 4;

  logic        CLK = 1'b0;
  logic        Reset, Start, IsLoad, PreIndex, Up, WriteBack;
  logic [3:0]  BaseReg;
  logic [31:0] BaseAddr;
  logic [15:0] RegList;
  logic [31:0] MemAddress, MemWD, MemRD, RegRD, RegWD;
  logic        MemWE, RegWE, Stall, Done;
  logic [3:0]  RegRA, RegWA;

  logic [31:0] rf [16];
  logic [31:0] mem_seed;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [31:0] s);
    return {a[15:0], a[31:16]} ^ s ^ 32'h3C3C_A5A5;
  endfunction

  assign MemRD = mem_fn(MemAddress, mem_seed);
  assign RegRD = rf[RegRA];

  ldm_stm_sequencer #(.ADDR_STEP(STEP), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .IsLoad(IsLoad), .PreIndex(PreIndex),
    .Up(Up), .WriteBack(WriteBack), .BaseReg(BaseReg), .BaseAddr(BaseAddr),
    .RegList(RegList), .MemAddress(MemAddress), .MemWE(MemWE), .MemWD(MemWD),
    .MemRD(MemRD), .RegRA(RegRA), .RegRD(RegRD), .RegWE(RegWE), .RegWA(RegWA),
    .RegWD(RegWD), .Stall(Stall), .Done(Done)
  );

  task automatic randomize_rf();
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
  endtask

  // Issue one command, watch it to completion, compare against the model.
  task automatic run_cmd(input logic ld, input logic p, input logic u, input logic w,
                         input logic [3:0] rn, input logic [31:0] base,
                         input logic [15:0] list, input bit noise);
    logic [31:0] snap [16];
    logic [31:0] exp_rf [16];
    int          idxs[$];
    logic [31:0] o_addr[$], o_data[$];
    logic [3:0]  o_reg[$];
    int          n_mem, n_ld, stall_n, done_k;
    bit          done_seen, wb_seen, wb_exp;
    logic [3:0]  wb_wa;
    logic [31:0] wb_wd, lo, nb, ea, ed;
    int          n;

    // Reference model: ascending register order at ascending addresses
    n = $countones(list);
    for (int i = 0; i < 16; i++) if (list[i]) idxs.push_back(i);
    for (int i = 0; i < 16; i++) snap[i] = rf[i];
    if (u) lo = base + (p ? 32'(STEP) : 32'd0);
    else   lo = base - 32'(n * STEP) + (p ? 32'd0 : 32'(STEP));
    nb     = u ? base + 32'(n * STEP) : base - 32'(n * STEP);
    wb_exp = w && !(ld && list[rn]);
    for (int i = 0; i < 16; i++) exp_rf[i] = snap[i];
    if (ld) foreach (idxs[k]) exp_rf[idxs[k]] = mem_fn(lo + 32'(k * STEP), mem_seed);
    if (wb_exp) exp_rf[rn] = nb;

    n_mem = 0; n_ld = 0; stall_n = 0; done_k = 0;
    done_seen = 0; wb_seen = 0; wb_wa = '0; wb_wd = '0;

    @(negedge CLK);
    IsLoad = ld; PreIndex = p; Up = u; WriteBack = w;
    BaseReg = rn; BaseAddr = base; RegList = list; Start = 1'b1;
    #1;
    n_cmp++;
    if (Stall !== 1'b1) begin
      n_err++; $display("FAIL start_stall: got %b want 1", Stall);
    end

    for (int k = 1; k <= 40 && !done_seen; k++) begin
      @(negedge CLK);
      if (Stall) stall_n++;
      if (MemWE) begin
        n_mem++; o_addr.push_back(MemAddress); o_data.push_back(MemWD); o_reg.push_back(RegRA);
      end
      if (RegWE && !Done) begin
        n_ld++; o_addr.push_back(MemAddress); o_data.push_back(RegWD); o_reg.push_back(RegWA);
      end
      if (RegWE && Done) begin
        wb_seen = 1; wb_wa = RegWA; wb_wd = RegWD;
      end
      if (RegWE) rf[RegWA] = RegWD;
      if (Done) begin
        done_seen = 1; done_k = k; Start = 1'b0;
      end else if (noise) begin
        Start = 1'($urandom); IsLoad = 1'($urandom); PreIndex = 1'($urandom);
        Up = 1'($urandom); WriteBack = 1'($urandom); BaseReg = 4'($urandom);
        BaseAddr = $urandom; RegList = 16'($urandom);
      end else begin
        Start = 1'b0;
      end
    end

    n_cmp++;
    if (!done_seen) begin
      n_err++; $display("FAIL done_timeout: no Done within 40 cycles, list %h", list);
    end else begin
      if (done_k != n + 1) begin
        n_err++; $display("FAIL done_latency: got %0d want %0d", done_k, n + 1);
      end
      n_cmp++;
      if (stall_n != n + 1) begin
        n_err++; $display("FAIL stall_cycles: got %0d want %0d", stall_n, n + 1);
      end
      n_cmp++;
      if (n_mem != (ld ? 0 : n) || n_ld != (ld ? n : 0)) begin
        n_err++; $display("FAIL xfer_count: mem %0d reg %0d want n=%0d ld=%b", n_mem, n_ld, n, ld);
      end else begin
        foreach (idxs[k]) begin
          ea = lo + 32'(k * STEP);
          ed = ld ? mem_fn(ea, mem_seed) : snap[idxs[k]];
          n_cmp++;
          if (o_addr[k] !== ea || o_data[k] !== ed || o_reg[k] !== 4'(idxs[k])) begin
            n_err++;
            $display("FAIL xfer[%0d]: got a=%h d=%h r=%0d want a=%h d=%h r=%0d",
                     k, o_addr[k], o_data[k], o_reg[k], ea, ed, idxs[k]);
          end
        end
      end
      n_cmp++;
      if (wb_seen !== wb_exp || (wb_exp && (wb_wa !== rn || wb_wd !== nb))) begin
        n_err++;
        $display("FAIL writeback: got en=%b r=%0d v=%h want en=%b r=%0d v=%h",
                 wb_seen, wb_wa, wb_wd, wb_exp, rn, nb);
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (rf[i] !== exp_rf[i]) begin
          n_err++; $display("FAIL regfile[%0d]: got %h want %h", i, rf[i], exp_rf[i]);
        end
      end
    end

    @(negedge CLK);
    Start = 1'b0;
    #1;
    n_cmp++;
    if ({Stall, MemWE, RegWE, Done} !== 4'b0 || MemAddress !== 32'h0 || MemWD !== 32'h0 || RegWD !== 32'h0) begin
      n_err++;
      $display("FAIL idle_after: got stall=%b we=%b rwe=%b done=%b addr=%h want all 0",
               Stall, MemWE, RegWE, Done, MemAddress);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; IsLoad = 0; PreIndex = 0; Up = 1; WriteBack = 0;
    BaseReg = '0; BaseAddr = 32'h1234; RegList = 16'h00FF;
    mem_seed = 32'h0; randomize_rf();
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({Stall, MemWE, RegWE, Done} !== 4'b0 || MemAddress !== 32'h0 || RegWA !== 4'h0 || RegRA !== 4'h0) begin
      n_err++; $display("FAIL reset_outputs: stall=%b we=%b rwe=%b done=%b addr=%h want 0",
                        Stall, MemWE, RegWE, Done, MemAddress);
    end
    Start = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({Stall, MemWE, RegWE, Done} !== 4'b0) begin
      n_err++; $display("FAIL idle_after_reset: got %b want 0000", {Stall, MemWE, RegWE, Done});
    end
  endtask

  task automatic test_stmia();
    randomize_rf();
    run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h0025, 1'b0);
    n_cmp++;
    if (rf[13] !== 32'h10C) begin
      n_err++; $display("FAIL stmia_base: got %h want 0000010c", rf[13]);
    end
  endtask

  task automatic test_ldmdb();
    randomize_rf(); mem_seed = $urandom;
    run_cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h200, 16'h000A, 1'b0);
    n_cmp++;
    if (rf[1] !== mem_fn(32'h1F8, mem_seed) || rf[3] !== mem_fn(32'h1FC, mem_seed) || rf[6] !== 32'h1F8) begin
      n_err++; $display("FAIL ldmdb_regs: got r1=%h r3=%h r6=%h", rf[1], rf[3], rf[6]);
    end
  endtask

  task automatic test_ldm_base_in_list();
    randomize_rf(); mem_seed = $urandom;
    run_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h400, 16'h0031, 1'b0);
    n_cmp++;
    if (rf[4] !== mem_fn(32'h404, mem_seed)) begin
      n_err++; $display("FAIL base_in_list: got %h want %h", rf[4], mem_fn(32'h404, mem_seed));
    end
  endtask

  task automatic test_empty();
    randomize_rf();
    run_cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h800, 16'h0000, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h800, 16'h0000, 1'b0);
  endtask

  task automatic test_full_wrap();
    randomize_rf();
    run_cmd(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 32'hFFFF_FFF8, 16'hFFFF, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r0, r13;
    int          writes;
    randomize_rf();
    r0 = rf[0]; r13 = rf[13]; writes = 0;
    @(negedge CLK);
    IsLoad = 0; PreIndex = 0; Up = 1; WriteBack = 1; BaseReg = 4'd13;
    BaseAddr = 32'h300; RegList = 16'h0015; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    if (MemWE) writes++;
    n_cmp++;
    if (MemWE !== 1'b1 || MemAddress !== 32'h300 || MemWD !== r0) begin
      n_err++; $display("FAIL first_word: got we=%b a=%h d=%h want 1 300 %h", MemWE, MemAddress, MemWD, r0);
    end
    @(posedge CLK);
    #1 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({Stall, MemWE, RegWE, Done} !== 4'b0 || MemAddress !== 32'h0 || MemWD !== 32'h0 || RegWD !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_outputs: stall=%b we=%b rwe=%b done=%b addr=%h wd=%h want 0",
                        Stall, MemWE, RegWE, Done, MemAddress, MemWD);
    end
    repeat (2) begin
      @(negedge CLK);
      if (MemWE) writes++;
      if (RegWE) rf[RegWA] = RegWD;
    end
    n_cmp++;
    if (writes != 1 || rf[13] !== r13) begin
      n_err++; $display("FAIL reset_mid_effects: writes %0d r13=%h want 1 %h", writes, rf[13], r13);
    end
    Reset = 1'b0;
    run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h300, 16'h0015, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] l;
    for (int t = 0; t < 25; t++) begin
      mem_seed = $urandom;
      if (t % 4 == 0) randomize_rf();
      l = 16'($urandom);
      if ($urandom_range(0, 7) == 0) l = 16'h0000;
      else if ($urandom_range(0, 7) == 0) l = 16'hFFFF;
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              $urandom, l, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_stmia();
    test_ldmdb();
    test_ldm_base_in_list();
    test_empty();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
